// File: rtl/veri_dwa_4to16.sv
// veri_dwa_4to16: data-weighted-averaging element selector for a 16-element unary DAC.
// Takes a 4-bit code k and asserts k unit elements per enabled cycle.
// Optional feature macro: DWA_ROTATE_EN
//   - defined: the selected run of k elements rotates, starting at a pointer that
//     advances by k each cycle.
//   - undefined: static thermometer mapping, elements 0..k-1; the pointer holds PTR_RST.
module veri_dwa_4to16 #(
    parameter int unsigned PTR_RST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  din,
    output logic [15:0] dout,
    output logic [3:0]  ptr,
    output logic [4:0]  ones
);

    localparam int unsigned NUM_ELEM = 16;
    localparam int unsigned PTR_W    = 4;

    logic [NUM_ELEM-1:0] therm;
    logic [NUM_ELEM-1:0] sel;
    logic [PTR_W-1:0]    ptr_nxt;

    // Thermometer mask with the low k bits set (2^k - 1).
    always_comb begin
        therm = '0;
        for (int i = 0; i < int'(NUM_ELEM); i++) begin
            if (i < int'(din)) therm[i] = 1'b1;
        end
    end

`ifdef DWA_ROTATE_EN
    logic [NUM_ELEM-1:0] rot_s0;
    logic [NUM_ELEM-1:0] rot_s1;
    logic [NUM_ELEM-1:0] rot_s2;
    logic [NUM_ELEM-1:0] rot_s3;

    // Four-stage barrel rotate-left of the mask by ptr; the pointer wraps modulo 16.
    always_comb begin
        rot_s0  = ptr[0] ? {therm[14:0],  therm[15]}     : therm;
        rot_s1  = ptr[1] ? {rot_s0[13:0], rot_s0[15:14]} : rot_s0;
        rot_s2  = ptr[2] ? {rot_s1[11:0], rot_s1[15:12]} : rot_s1;
        rot_s3  = ptr[3] ? {rot_s2[7:0],  rot_s2[15:8]}  : rot_s2;
        sel     = rot_s3;
        ptr_nxt = ptr + din;
    end
`else
    // Static mapping: elements 0..k-1, the pointer never moves.
    always_comb begin
        sel     = therm;
        ptr_nxt = ptr;
    end
`endif

    // Output and pointer registers; en low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            ptr  <= PTR_W'(PTR_RST);
            ones <= '0;
        end else if (en) begin
            dout <= sel;
            ptr  <= ptr_nxt;
            ones <= {1'b0, din};
        end
    end

endmodule

// File: tb/tb_veri_dwa_4to16.sv
// tb_veri_dwa_4to16: self-checking bench for veri_dwa_4to16.
// Follows the DWA_ROTATE_EN macro in the same way as the design.
// The reference model builds each element pattern one element at a time from the pointer and k.
module tb_veri_dwa_4to16;

    localparam int unsigned PTR_RST = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [3:0]  din = '0;
    logic [15:0] dout;
    logic [3:0]  ptr;
    logic [4:0]  ones;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [15:0] m_dout;
    logic [3:0]  m_ptr;
    logic [4:0]  m_ones;

    int usage[16];

    typedef struct {
        logic [3:0]  din;
        logic        en;
        logic [15:0] exp_dout;
        logic [3:0]  exp_ptr;
        logic [4:0]  exp_ones;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    veri_dwa_4to16 #(.PTR_RST(PTR_RST)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din),
        .dout (dout),
        .ptr  (ptr),
        .ones (ones)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dout = '0;
        m_ones = '0;
        m_ptr  = 4'(PTR_RST);
    endtask

    task automatic model_step(input logic [3:0] k, input logic e);
        int k_i;
        k_i = int'(k);
        if (!e) return;
        m_dout = '0;
`ifdef DWA_ROTATE_EN
        for (int j = 0; j < k_i; j++) m_dout[4'((int'(m_ptr) + j) % 16)] = 1'b1;
        m_ptr = 4'((int'(m_ptr) + k_i) % 16);
`else
        for (int j = 0; j < k_i; j++) m_dout[4'(j)] = 1'b1;
`endif
        m_ones = 5'(k_i);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'(m_dout));
        chk({tag, "_ptr"},  32'(ptr),  32'(m_ptr));
        chk({tag, "_ones"}, 32'(ones), 32'(m_ones));
    endtask

    // Drive on the falling edge, update the model at the rising edge, sample 1 time unit later.
    task automatic step(input logic [3:0] d, input logic e);
        @(negedge clk);
        din = d;
        en  = e;
        @(posedge clk);
        model_step(d, e);
        #1;
    endtask

    // Reset held low across a rising edge with an active code at the input.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        din = 4'd9;
        en  = 1'b1;
        #1;
        model_reset();
        chk_model("reset_async");
        @(posedge clk);
        #1;
        chk_model("reset_held");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int mn;
        int mx;
        logic e;
        logic [3:0] d;

`ifdef DWA_ROTATE_EN
        vecs[0] = '{din: 4'd5,  en: 1'b1, exp_dout: 16'h001F, exp_ptr: 4'd5,  exp_ones: 5'd5};
        vecs[1] = '{din: 4'd5,  en: 1'b1, exp_dout: 16'h03E0, exp_ptr: 4'd10, exp_ones: 5'd5};
        vecs[2] = '{din: 4'd9,  en: 1'b1, exp_dout: 16'hFC07, exp_ptr: 4'd3,  exp_ones: 5'd9};
        vecs[3] = '{din: 4'd0,  en: 1'b1, exp_dout: 16'h0000, exp_ptr: 4'd3,  exp_ones: 5'd0};
        vecs[4] = '{din: 4'd15, en: 1'b1, exp_dout: 16'hFFFB, exp_ptr: 4'd2,  exp_ones: 5'd15};
        vecs[5] = '{din: 4'd7,  en: 1'b0, exp_dout: 16'hFFFB, exp_ptr: 4'd2,  exp_ones: 5'd15};
`else
        vecs[0] = '{din: 4'd5,  en: 1'b1, exp_dout: 16'h001F, exp_ptr: 4'd0, exp_ones: 5'd5};
        vecs[1] = '{din: 4'd5,  en: 1'b1, exp_dout: 16'h001F, exp_ptr: 4'd0, exp_ones: 5'd5};
        vecs[2] = '{din: 4'd9,  en: 1'b1, exp_dout: 16'h01FF, exp_ptr: 4'd0, exp_ones: 5'd9};
        vecs[3] = '{din: 4'd0,  en: 1'b1, exp_dout: 16'h0000, exp_ptr: 4'd0, exp_ones: 5'd0};
        vecs[4] = '{din: 4'd15, en: 1'b1, exp_dout: 16'h7FFF, exp_ptr: 4'd0, exp_ones: 5'd15};
        vecs[5] = '{din: 4'd7,  en: 1'b0, exp_dout: 16'h7FFF, exp_ptr: 4'd0, exp_ones: 5'd15};
`endif

        // Directed table: rotation, wrap, k = 0, k = 15, hold.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].din, vecs[i].en);
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_ptr",  i), 32'(ptr),  32'(vecs[i].exp_ptr));
            chk($sformatf("vec%0d_ones", i), 32'(ones), 32'(vecs[i].exp_ones));
        end

        // Enable hold with every nonzero code, then resume.
        do_reset();
        step(4'd5, 1'b1);
        step(4'd5, 1'b1);
        chk_model("pre_hold");
        for (int v = 1; v < 16; v++) begin
            step(4'(v), 1'b0);
            chk_model($sformatf("hold%0d", v));
        end
        step(4'd2, 1'b1);
        chk_model("resume");
`ifdef DWA_ROTATE_EN
        chk("resume_const_dout", 32'(dout), 32'h0C00);
        chk("resume_const_ptr",  32'(ptr),  32'd12);
`else
        chk("resume_const_dout", 32'(dout), 32'h0003);
        chk("resume_const_ptr",  32'(ptr),  32'd0);
`endif

        // Asynchronous reset pulse between clock edges.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_model("midreset");
        @(negedge clk);
        rst = 1'b1;
        step(4'd3, 1'b1);
        chk_model("post_midreset");
        chk("post_midreset_const", 32'(dout), 32'h0007);

        // Randomized run against the model, tracking per-element usage.
        do_reset();
        for (int i = 0; i < 16; i++) usage[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            e = ($urandom_range(0, 9) != 0);
            d = 4'($urandom_range(0, 15));
            step(d, e);
            chk_model("rand");
            if (e) begin
                for (int i = 0; i < 16; i++) usage[i] += int'(dout[i]);
            end
        end
        mn = usage[0];
        mx = usage[0];
        for (int i = 1; i < 16; i++) begin
            if (usage[i] < mn) mn = usage[i];
            if (usage[i] > mx) mx = usage[i];
        end
`ifdef DWA_ROTATE_EN
        chk("usage_spread_le1", 32'((mx - mn) <= 1), 32'd1);
`else
        chk("static_elem15_unused", 32'(usage[15]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
